// File: rtl/i2s_tx_pkg.sv
// Shared types and defaults for the I2S transmitter.
// State encodings and sample geometry shared with the synth.
package i2s_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } i2s_state_e;

  localparam int BITWIDTH_DEF   = 24;
  localparam int SLOT_WIDTH_DEF = 32;
  localparam int BCLK_DIV_DEF   = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV cycles while running.
// Edge strobes are valid in the cycle whose closing edge moves bclk.
module i2s_bclk_gen
  import i2s_tx_pkg::*;
#(
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic bclk_o,
  output logic rise_evt_o,
  output logic fall_evt_o
);

  localparam int DW = cnt_w(BCLK_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          tc;

  assign tc         = run_i & ~clr_i & (div_q == DIV_TC);
  assign rise_evt_o = tc & ~bclk_q;
  assign fall_evt_o = tc & bclk_q;
  assign bclk_o     = bclk_q;

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (clr_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (run_i) begin
      if (tc) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: mono sample duplicated into both slots.
// Paces the synth with one aud_freq strobe per stereo frame.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int BITWIDTH   = BITWIDTH_DEF,
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
  parameter int BCLK_DIV   = BCLK_DIV_DEF
) (
  input  logic                ctl_clk,
  input  logic                ctl_rst,
  input  logic                enable,
  input  logic [BITWIDTH-1:0] sample_in,
  output logic                aud_freq,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                busy
);

  localparam int PW = cnt_w(SLOT_WIDTH);
  localparam int BW = cnt_w(BITWIDTH);
  localparam logic [PW-1:0] P_LAST = PW'(SLOT_WIDTH - 1);
  localparam logic [PW-1:0] P_MSB  = PW'(BITWIDTH);

  i2s_state_e          state_q, state_d;
  logic [PW-1:0]       p_q, p_d;
  logic                lrclk_q, lrclk_d;
  logic [BITWIDTH-1:0] hold_q, hold_d;
  logic                aud_q, aud_d;
  logic                sdata_q, sdata_d;
  logic [BW-1:0]       bidx;

  logic bclk;
  logic fall_evt;
  logic unused_rise;
  logic frame_end;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk (
    .clk_i      (ctl_clk),
    .rst_ni     (ctl_rst),
    .run_i      (state_q != ST_IDLE),
    .clr_i      (state_q == ST_IDLE),
    .bclk_o     (bclk),
    .rise_evt_o (unused_rise),
    .fall_evt_o (fall_evt)
  );

  // Right slot wrapping back to left: the frame boundary.
  assign frame_end = fall_evt & lrclk_q & (p_q == P_LAST);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    lrclk_d = lrclk_q;
    hold_d  = hold_q;
    aud_d   = 1'b0;
    sdata_d = 1'b0;
    bidx    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          hold_d  = sample_in;
          aud_d   = 1'b1;
          p_d     = '0;
          lrclk_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        state_d = enable ? ST_RUN : ST_DRAIN;
        if (fall_evt) begin
          if (p_q == P_LAST) begin
            p_d     = '0;
            lrclk_d = ~lrclk_q;
          end else begin
            p_d = p_q + PW'(1);
          end
        end
        if (frame_end) begin
          if (state_q == ST_RUN || enable) begin
            hold_d = sample_in;
            aud_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            p_d     = '0;
            lrclk_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // p=0 is the one-bit delay slot; past the MSB count is padding.
    if (state_d != ST_IDLE && p_d != '0 && p_d <= P_MSB) begin
      bidx    = BW'(BITWIDTH - int'(p_d));
      sdata_d = hold_d[bidx];
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      lrclk_q <= 1'b0;
      hold_q  <= '0;
      aud_q   <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      lrclk_q <= lrclk_d;
      hold_q  <= hold_d;
      aud_q   <= aud_d;
      sdata_q <= sdata_d;
    end
  end

  assign aud_freq  = aud_q;
  assign i2s_bclk  = bclk;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with BCLK_DIV=2 (256-cycle frames).
// Cycle n counts rising edges from the enable latch edge (n=0).
module tb_i2s_tx;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] sample;
  logic        aud_freq;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        busy;

  int checks;
  int passed;

  i2s_tx #(
    .BITWIDTH   (24),
    .SLOT_WIDTH (32),
    .BCLK_DIV   (2)
  ) dut (
    .ctl_clk   (clk),
    .ctl_rst   (rst_n),
    .enable    (enable),
    .sample_in (sample),
    .aud_freq  (aud_freq),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Wire bit after edge n: slot position p = (n/4) mod 32.
  function automatic logic exp_sdata(input logic [23:0] pat, input int n);
    int p;
    logic [23:0] t;
    p = ((n % 256) / 4) % 32;
    if (p < 1 || p > 24) return 1'b0;
    t = pat >> (24 - p);
    return t[0];
  endfunction

  task automatic span(input int n0, input int n1, input logic [23:0] pat,
                      input logic busy_e);
    for (int n = n0; n <= n1; n++) begin
      tick();
      chk("bclk", i2s_bclk, (n % 4) >= 2);
      chk("lrclk", i2s_lrclk, (n % 256) >= 128);
      chk("sdata", i2s_sdata, exp_sdata(pat, n));
      chk("aud_freq", aud_freq, (n % 256) == 0);
      chk("busy", busy, busy_e);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_aud"}, aud_freq, 1'b0);
    chk({tag, "_bclk"}, i2s_bclk, 1'b0);
    chk({tag, "_lrclk"}, i2s_lrclk, 1'b0);
    chk({tag, "_sdata"}, i2s_sdata, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [23:0] bits;
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    enable = 1'b1;
    sample = 24'hA50F3C;

    repeat (3) tick();
    all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pre_latch_aud", aud_freq, 1'b0);
    chk("pre_latch_busy", busy, 1'b0);

    // Explicit slot bit pattern for A50F3C, left slot p=1..24.
    bits = 24'b1010_0101_0000_1111_0011_1100;
    tick();
    chk("start_aud", aud_freq, 1'b1);
    for (int p = 0; p < 32; p++) begin
      repeat (4) tick();
      chk("left_bit", i2s_sdata, (p >= 24) ? 1'b0 : bits[23 - p]);
    end
    // Now after edge 128: right slot, p=0.
    chk("right_lr", i2s_lrclk, 1'b1);
    chk("right_p0", i2s_sdata, 1'b0);
    sample = 24'h123456;
    span(129, 255, 24'hA50F3C, 1'b1);
    span(256, 300, 24'h123456, 1'b1);
    sample = 24'hC0FFEE;
    span(301, 511, 24'h123456, 1'b1);

    span(512, 552, 24'hC0FFEE, 1'b1);
    enable = 1'b0;
    span(553, 767, 24'hC0FFEE, 1'b1);
    tick();
    all_zero("drain_end");
    repeat (2) tick();
    all_zero("idle");

    sample = 24'h0F0F0F;
    enable = 1'b1;
    span(0, 40, 24'h0F0F0F, 1'b1);
    enable = 1'b0;
    span(41, 99, 24'h0F0F0F, 1'b1);
    enable = 1'b1;
    sample = 24'h9E3779;
    span(100, 255, 24'h0F0F0F, 1'b1);
    span(256, 406, 24'h9E3779, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    span(0, 140, 24'h9E3779, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
